// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: round-robin ALU/LSU writeback
// arbitration, registered write port, busy scoreboard and issue hazard stall.
module rf_wb_arbiter #(
  parameter int unsigned CPU_WIDTH = 32,
  parameter int unsigned REG_ADDRW = 5,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_iss_valid,
  input  logic                 i_iss_wen,
  input  logic [REG_ADDRW-1:0] i_iss_rd,
  input  logic [REG_ADDRW-1:0] i_iss_rs1,
  input  logic [REG_ADDRW-1:0] i_iss_rs2,
  output logic                 o_iss_stall,
  input  logic                 i_alu_valid,
  input  logic [REG_ADDRW-1:0] i_alu_rd,
  input  logic [CPU_WIDTH-1:0] i_alu_data,
  output logic                 o_alu_ready,
  input  logic                 i_lsu_valid,
  input  logic [REG_ADDRW-1:0] i_lsu_rd,
  input  logic [CPU_WIDTH-1:0] i_lsu_data,
  output logic                 o_lsu_ready,
  output logic                 o_rf_wen,
  output logic [REG_ADDRW-1:0] o_rf_waddr,
  output logic [CPU_WIDTH-1:0] o_rf_wdata,
  output logic [REG_COUNT-1:0] o_busy,
  output logic                 o_err
);

  // 1 = ALU wins the next contended cycle, 0 = LSU wins
  logic                 ptr_alu;
  logic                 contended;
  logic                 grant;
  logic [REG_ADDRW-1:0] grant_rd;
  logic [CPU_WIDTH-1:0] grant_data;
  logic                 iss_accept;
  logic [REG_COUNT-1:0] busy_nxt;

  assign contended = i_alu_valid & i_lsu_valid;

  // Grant selection: a lone requester always wins, otherwise the pointer decides
  always_comb begin
    o_alu_ready = i_alu_valid & (~i_lsu_valid | ptr_alu);
    o_lsu_ready = i_lsu_valid & (~i_alu_valid | ~ptr_alu);
    grant       = o_alu_ready | o_lsu_ready;
    grant_rd    = o_alu_ready ? i_alu_rd   : i_lsu_rd;
    grant_data  = o_alu_ready ? i_alu_data : i_lsu_data;
  end

  // Hazard stall: RAW on either source or WAW on rd; x0 is never busy
  always_comb begin
    o_iss_stall = i_iss_valid &
                  (o_busy[i_iss_rs1] | o_busy[i_iss_rs2] | (i_iss_wen & o_busy[i_iss_rd]));
    iss_accept  = i_iss_valid & i_iss_wen & ~o_iss_stall & (i_iss_rd != REG_ADDRW'(0));
  end

  // Scoreboard update: clear on commit, set on issue (set wins), x0 pinned low
  always_comb begin
    busy_nxt = o_busy;
    if (o_rf_wen) begin
      busy_nxt[o_rf_waddr] = 1'b0;
    end
    if (iss_accept) begin
      busy_nxt[i_iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Round-robin pointer flips only when both sources competed
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_alu <= 1'b1;
    end else if (contended) begin
      ptr_alu <= ~ptr_alu;
    end
  end

  // Registered write port; rd=0 grants are consumed without a write
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rf_wen   <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else begin
      o_rf_wen <= grant & (grant_rd != REG_ADDRW'(0));
      if (grant && (grant_rd != REG_ADDRW'(0))) begin
        o_rf_waddr <= grant_rd;
        o_rf_wdata <= grant_data;
      end
    end
  end

  // Scoreboard state and sticky error on writes to non-busy registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy <= '0;
      o_err  <= 1'b0;
    end else begin
      o_busy <= busy_nxt;
      if (o_rf_wen && (o_rf_waddr != REG_ADDRW'(0)) && !o_busy[o_rf_waddr]) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Controller in front of the integer register file's single write port.
- Arbitrates round-robin between the ALU and LSU writeback sources and registers the winning write onto the regfile write port.
- Keeps a per-register busy scoreboard: set at issue, cleared at write commit.
- Drives an issue stall on RAW and WAW hazards against in-flight writes.

Parameters:
CPU_WIDTH, 32, data width of regfile entries
REG_ADDRW, 5, register address width
REG_COUNT, 32, number of architectural registers (2**REG_ADDRW)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  reset, asynchronous, active-high
i_iss_valid  input  1  decode presents an instruction for issue
i_iss_wen  input  1  issuing instruction writes rd
i_iss_rd  input  REG_ADDRW  destination of issuing instruction
i_iss_rs1  input  REG_ADDRW  source 1 of issuing instruction
i_iss_rs2  input  REG_ADDRW  source 2 of issuing instruction
o_iss_stall  output  1  hazard, issue not accepted this cycle
i_alu_valid  input  1  ALU writeback request
i_alu_rd  input  REG_ADDRW  ALU writeback address
i_alu_data  input  CPU_WIDTH  ALU writeback data
o_alu_ready  output  1  ALU request granted this cycle
i_lsu_valid  input  1  LSU (load) writeback request
i_lsu_rd  input  REG_ADDRW  LSU writeback address
i_lsu_data  input  CPU_WIDTH  LSU writeback data
o_lsu_ready  output  1  LSU request granted this cycle
o_rf_wen  output  1  regfile write enable
o_rf_waddr  output  REG_ADDRW  regfile write address
o_rf_wdata  output  CPU_WIDTH  regfile write data
o_busy  output  REG_COUNT  scoreboard vector, bit n = xn has a pending write
o_err  output  1  sticky: writeback to a register not marked busy

Behaviour:
- Reset (async, immediate):
  - o_rf_wen=0, o_rf_waddr=0, o_rf_wdata=0.
  - o_busy=0, o_err=0.
  - Round-robin pointer set to ALU-first.
  - Any in-flight handshake is dropped, with no write issued.
- Handshake:
  - valid/ready; a source holds valid, rd and data stable until ready.
  - Transfer occurs when valid & ready on a clock edge.
  - ready is combinational from valid and the pointer.
  - ready never asserts without the matching valid.
- Arbitration (one grant per cycle):
  - Only one source valid: that source is granted.
  - Both valid: grant the source the pointer favours; the pointer then flips to favour the other source.
  - Pointer changes only on a contended grant. An uncontested grant leaves the pointer unchanged.
- Write port:
  - Registered with 1-cycle latency. A grant at edge N gives o_rf_wen=1 with the granted rd/data during cycle N+1; the regfile writes at edge N+1.
  - No grant gives o_rf_wen=0; waddr/wdata hold their last values.
  - A grant with rd=0 is accepted (ready=1) but produces o_rf_wen=0.
- Scoreboard:
  - busy[rd] is set at the edge where the issue is accepted, i.e. i_iss_valid & i_iss_wen & ~o_iss_stall & rd!=0.
  - busy[o_rf_waddr] is cleared at the edge where o_rf_wen=1 (the same edge the regfile commits).
  - busy[0] is constantly 0.
- Stall (combinational):
  - o_iss_stall = i_iss_valid & (busy[rs1] | busy[rs2] | (i_iss_wen & busy[rd])).
  - Reads of x0 never stall.
  - No bypass: a register clearing this cycle still stalls; issue proceeds the next cycle.
- Simultaneous set and clear of the same bit:
  - Cannot legally occur, because WAW stalls.
  - If forced, set wins.
- Error:
  - o_err is set when o_rf_wen=1 targets a nonzero address whose busy bit is 0.
  - Remains set until reset.
- Writeback sources never stall. Unbounded starvation is impossible: under sustained contention each source is granted at least every 2nd cycle.

Test Plan:
- Reset mid-write: ALU grant (rd=5, data=0xDEADBEEF) at edge N, i_rst asserted before edge N+1 -> o_rf_wen=0 immediately, o_busy=0, no write at N+1.
- Single ALU writeback: issue rd=3, then ALU valid rd=3 data=0x12345678 -> o_alu_ready=1 same cycle; next cycle o_rf_wen=1, waddr=3, wdata=0x12345678; busy[3] cleared after that edge; o_err=0.
- Contention: issue rd=4 and rd=7; ALU(rd=4, 0xA) and LSU(rd=7, 0xB) both valid from reset -> ALU granted first, LSU next cycle; writes appear on consecutive cycles in that order; pointer then favours LSU.
- RAW stall: issue lw rd=8, then add rs1=8 -> o_iss_stall=1 until the cycle after LSU write of x8 commits; the add must not issue in the commit cycle itself.
- WAW and x0: issue rd=9 and, while it is pending, issue again with rd=9 -> stall. Issue with rd=0 -> no stall, busy[0]=0; writeback to rd=0 gives ready=1 and o_rf_wen=0.
- Error flag: LSU writeback rd=12 with busy[12]=0 -> o_err=1 after the write cycle, and it stays 1 until i_rst.
